// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Memory-stage access controller. Accepts one load/store at a
//               time from EX/MEM over valid/ready, sequences MemWr/MemRd to
//               match dmem timing (write on negedge, read on MemRd rising
//               edge) and returns a one-cycle completion pulse to MEM/WB.
// Parameters  : RD_HOLD - cycles MemRd stays high before Dataout is captured
//               (1..7).
// Options     : MAC_ADDR_CHECK_EN - when defined, requests with
//               req_addr[15:5] != 0 are rejected with rsp_err=1 and never
//               reach dmem.
// Ports       : clk, reset               - clock, sync active-high reset
//               req_valid/req_ready      - request handshake
//               req_wr/req_addr/req_wdata- request payload
//               rsp_valid/rsp_data/rsp_err - completion
//               MemRd/MemWr/address/DataIn - to dmem
//               Dataout                  - from dmem
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int RD_HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        MemRd,
    output logic        MemWr,
    output logic [15:0] address,
    output logic [15:0] DataIn,
    input  logic [15:0] Dataout
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_RD_SETUP  = 2'd2,
        S_RD_STROBE = 2'd3
    } state_t;

    localparam logic [2:0] c_hold_load = 3'(RD_HOLD - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_memrd, w_memrd_nxt;
    logic        r_memwr, w_memwr_nxt;
    logic [15:0] r_address, w_address_nxt;
    logic [15:0] r_datain, w_datain_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic [15:0] r_rsp_data, w_rsp_data_nxt;
    logic        r_rsp_err, w_rsp_err_nxt;
    logic        r_err_pend, w_err_pend_nxt;
    logic        w_addr_bad;

`ifdef MAC_ADDR_CHECK_EN
    // dmem only decodes 32 words; anything above is an access violation.
    assign w_addr_bad = |req_addr[15:5];
`else
    // Every address is forwarded; the error path is constant-folded away.
    assign w_addr_bad = 1'b0;
`endif

    assign req_ready = (r_state == S_IDLE);
    assign MemRd     = r_memrd;
    assign MemWr     = r_memwr;
    assign address   = r_address;
    assign DataIn    = r_datain;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_memrd     <= 1'b0;
            r_memwr     <= 1'b0;
            r_address   <= 16'h0000;
            r_datain    <= 16'h0000;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_rsp_err   <= 1'b0;
            r_err_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_memrd     <= w_memrd_nxt;
            r_memwr     <= w_memwr_nxt;
            r_address   <= w_address_nxt;
            r_datain    <= w_datain_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_err_pend  <= w_err_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_memrd_nxt     = r_memrd;
        w_memwr_nxt     = 1'b0;        // write enable is a single-cycle pulse
        w_address_nxt   = r_address;
        w_datain_nxt    = r_datain;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;
        w_err_pend_nxt  = r_err_pend;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_addr_bad) begin
                        // Rejected: burn one WRITE cycle with dmem untouched.
                        w_err_pend_nxt = 1'b1;
                        w_state_nxt    = S_WRITE;
                    end else if (req_wr) begin
                        w_err_pend_nxt = 1'b0;
                        w_address_nxt  = req_addr;
                        w_datain_nxt   = req_wdata;
                        w_memwr_nxt    = 1'b1;
                        w_state_nxt    = S_WRITE;
                    end else begin
                        // Address settles one cycle with MemRd low so the
                        // following rise is a clean read trigger.
                        w_err_pend_nxt = 1'b0;
                        w_address_nxt  = req_addr;
                        w_state_nxt    = S_RD_SETUP;
                    end
                end
            end
            S_WRITE: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = r_err_pend;
                if (r_err_pend) begin
                    w_rsp_data_nxt = 16'h0000;
                end
                w_err_pend_nxt  = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            S_RD_SETUP: begin
                w_memrd_nxt = 1'b1;
                w_cnt_nxt   = c_hold_load;
                w_state_nxt = S_RD_STROBE;
            end
            S_RD_STROBE: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    w_rsp_data_nxt  = Dataout;
                    w_memrd_nxt     = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_memrd_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
